// File: rtl/alu_writeback.sv
// alu_writeback: registers ALU results with flags, maintains the status register,
// sticky overflow and a saturating op counter, and buffers results in a 2-entry
// FIFO toward the register-file write port.
module alu_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ALUoutput,
    input  logic              carry,
    input  logic              overflow,
    input  logic              equal,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              wb_en,
    input  logic              flag_en,
    input  logic              clr_sticky,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_dest,
    output logic              out_wb_en,
    output logic [4:0]        status,
    output logic              sticky_ovf,
    output logic [CNT_W-1:0]  op_count
);

    logic [1:0][DATA_W-1:0] data_q;
    logic [1:0][ADDR_W-1:0] dest_q;
    logic [1:0]             wb_q;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic                   push;
    logic                   pop;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);

    // Head is read straight from the storage registers, so there is no
    // combinational path from the inputs to out_*.
    assign out_data  = data_q[rd_ptr];
    assign out_dest  = dest_q[rd_ptr];
    assign out_wb_en = wb_q[rd_ptr];

    // FIFO storage, pointers and occupancy; reset clears entries so out_* read 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            dest_q <= '0;
            wb_q   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= ALUoutput;
                dest_q[wr_ptr] <= dest_addr;
                wb_q[wr_ptr]   <= wb_en;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Status {N,Z,V,C,EQ} updates when a flag-enabled result is accepted, not when popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= 5'b0;
        end else if (push && flag_en) begin
            status <= {ALUoutput[DATA_W-1], (ALUoutput == '0), overflow, carry, equal};
        end
    end

    // Sticky overflow: setting takes priority over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (push && flag_en && overflow) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

    // Saturating count of accepted results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (push && (op_count != '1)) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Testbench for alu_writeback: scoreboard of accepted entries, table-driven
// status/sticky vectors and directed FIFO corner sequences.
module tb_alu_writeback;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic        carry;
    logic        overflow;
    logic        equal;
    logic [2:0]  dest_addr;
    logic        wb_en;
    logic        flag_en;
    logic        clr_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_dest;
    logic        out_wb_en;
    logic [4:0]  status;
    logic        sticky_ovf;
    logic [15:0] op_count;

    // small-counter instance for the saturation check
    logic        in_ready2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] out_data2;
    logic [2:0]  out_dest2;
    logic        out_wb_en2;
    logic [4:0]  status2;
    logic        sticky_ovf2;
    logic [1:0]  op_count2;

    alu_writeback #(.DATA_W(32), .ADDR_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUoutput(alu_out), .carry(carry), .overflow(overflow), .equal(equal),
        .dest_addr(dest_addr), .wb_en(wb_en), .flag_en(flag_en), .clr_sticky(clr_sticky),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dest(out_dest), .out_wb_en(out_wb_en), .status(status),
        .sticky_ovf(sticky_ovf), .op_count(op_count)
    );

    alu_writeback #(.DATA_W(32), .ADDR_W(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .ALUoutput(alu_out), .carry(carry), .overflow(overflow), .equal(equal),
        .dest_addr(dest_addr), .wb_en(wb_en), .flag_en(flag_en), .clr_sticky(clr_sticky),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_dest(out_dest2), .out_wb_en(out_wb_en2), .status(status2),
        .sticky_ovf(sticky_ovf2), .op_count(op_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  dest;
        logic        wb;
    } entry_t;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        c;
        logic        v;
        logic        eq;
        logic        fe;
        logic        clr;
        logic [4:0]  exp_status;
        logic        exp_sticky;
    } vec_t;

    entry_t      sb_q[$];
    logic [31:0] pop_log[$];
    int          m_cnt;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] a,
                         input logic w, input logic c, input logic o, input logic e,
                         input logic fe, input logic clr);
        in_valid   = v;
        alu_out    = d;
        dest_addr  = a;
        wb_en      = w;
        carry      = c;
        overflow   = o;
        equal      = e;
        flag_en    = fe;
        clr_sticky = clr;
    endtask

    // One clock: score pop/accept from pre-edge values, then check handshake state after.
    task automatic tick();
        logic   acc;
        logic   pp;
        entry_t e;
        acc = in_valid && in_ready;
        pp  = out_valid && out_ready;
        if (pp) begin
            if (sb_q.size() == 0) begin
                check("pop_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                e = sb_q.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_dest", 64'(out_dest), 64'(e.dest));
                check("out_wb_en", 64'(out_wb_en), 64'(e.wb));
                pop_log.push_back(out_data);
            end
        end
        if (acc) begin
            sb_q.push_back('{data: alu_out, dest: dest_addr, wb: wb_en});
            if (m_cnt != 65535) m_cnt++;
        end
        @(posedge clk);
        #1;
        check("in_ready", 64'(in_ready), 64'(sb_q.size() != 2));
        check("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
        check("op_count", 64'(op_count), 64'(m_cnt));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        pop_log.delete();
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[7];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        m_cnt      = 0;
        out_ready  = 1'b0;
        out_ready2 = 1'b1;
        drive(0, 32'h0, 3'd0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;

        vecs[0] = '{1'b1, 32'h8000_0000, 1, 1, 0, 1, 0, 5'b10110, 1'b1};
        vecs[1] = '{1'b1, 32'h0000_0000, 0, 0, 0, 1, 0, 5'b01000, 1'b1};
        vecs[2] = '{1'b1, 32'h0000_1234, 0, 1, 1, 1, 1, 5'b00101, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0007, 1, 1, 0, 0, 0, 5'b00101, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0000, 0, 0, 0, 0, 1, 5'b00101, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 1, 0, 1, 1, 0, 5'b10011, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0000, 0, 1, 0, 1, 0, 5'b10011, 1'b0};

        // Test 1: reset with two entries buffered and non-zero status
        @(negedge clk);
        out_ready = 1'b0;
        drive(1, 32'h8000_0000, 3'd1, 1, 1, 1, 0, 1, 0);
        tick();
        drive(1, 32'h0000_0022, 3'd2, 1, 0, 0, 0, 0, 0);
        tick();
        check("pre_reset_status", 64'(status), 64'(5'b10110));
        drive(0, 32'h0, 3'd0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_status", 64'(status), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_sticky", 64'(sticky_ovf), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        sb_q.delete();
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Test 2: single accept, visible next cycle, popped the cycle after
        out_ready = 1'b1;
        drive(1, 32'h0000_0005, 3'd3, 1, 0, 0, 0, 1, 0);
        tick();
        check("t2_out_data", 64'(out_data), 64'h5);
        check("t2_out_dest", 64'(out_dest), 64'd3);
        check("t2_status", 64'(status), 64'(5'b00000));
        drive(0, 32'h0, 3'd0, 0, 0, 0, 0, 0, 0);
        tick();
        check("t2_drained", 64'(out_valid), 64'd0);

        // Test 3: fill while stalled, third result held off, then drain in order
        do_reset();
        out_ready = 1'b0;
        drive(1, 32'hA, 3'd1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'hB, 3'd2, 0, 0, 0, 0, 0, 0);
        tick();
        check("t3_full", 64'(in_ready), 64'd0);
        drive(1, 32'hC, 3'd3, 1, 0, 0, 0, 0, 0);
        tick();
        check("t3_c_held", 64'(op_count), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (sb_q.size() == 0 || (sb_q.size() == 1 && !in_ready)) ;
            if (!in_ready) ;
            if (op_count == 16'd3) drive(0, 32'h0, 3'd0, 0, 0, 0, 0, 0, 0);
        end
        tick();
        check("t3_op_count", 64'(op_count), 64'd3);
        check("t3_pop_n", 64'(pop_log.size()), 64'd3);
        if (pop_log.size() == 3) begin
            check("t3_order0", 64'(pop_log[0]), 64'hA);
            check("t3_order1", 64'(pop_log[1]), 64'hB);
            check("t3_order2", 64'(pop_log[2]), 64'hC);
        end

        // Test 4: hold occupancy at 1 with simultaneous push+pop
        do_reset();
        out_ready = 1'b0;
        drive(1, 32'h100, 3'd0, 1, 0, 0, 0, 0, 0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h200 + 32'(i), 3'(i), i[0], 0, 0, 0, 0, 0);
            tick();
            check("t4_count1", 64'(sb_q.size()), 64'd1);
        end
        drive(0, 32'h0, 3'd0, 0, 0, 0, 0, 0, 0);
        tick();
        check("t4_pop_n", 64'(pop_log.size()), 64'd9);
        if (pop_log.size() == 9) begin
            check("t4_first", 64'(pop_log[0]), 64'h100);
            for (int i = 1; i < 9; i++) check("t4_order", 64'(pop_log[i]), 64'(32'h1FF + 32'(i)));
        end

        // Tests 5/6: status and sticky overflow vectors
        do_reset();
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].data, 3'(i), 1, vecs[i].c, vecs[i].v,
                  vecs[i].eq, vecs[i].fe, vecs[i].clr);
            tick();
            check($sformatf("status_v%0d", i), 64'(status), 64'(vecs[i].exp_status));
            check($sformatf("sticky_v%0d", i), 64'(sticky_ovf), 64'(vecs[i].exp_sticky));
        end
        drive(0, 32'h0, 3'd0, 0, 0, 0, 0, 0, 0);
        tick();

        // Test 6: 2-bit counter saturates at 3
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(1, 32'(k), 3'(k), 1, 0, 0, 0, 0, 0);
            tick();
            check("sat_op_count", 64'(op_count2), 64'((k > 3) ? 3 : k));
        end
        drive(0, 32'h0, 3'd0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
